tlp_traffic_checker: RTL and testbench



---
 rtl/tlp_traffic_checker_pkg.sv | 18 +
 rtl/tlp_prbs_lfsr.sv | 27 ++
 rtl/tlp_traffic_checker.sv | 117 +++++++++++
 tb/tb_tlp_traffic_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_traffic_checker_pkg.sv
// tlp_traffic_checker_pkg: channel state encoding and PRBS constants shared by the traffic checker.
package tlp_traffic_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] LFSR_POLY         = 32'h04C1_1DB7;
    localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE1_0001;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/tlp_prbs_lfsr.sv
// tlp_prbs_lfsr: 32-bit Galois PRBS with reseed/step; word output is the state replicated and truncated.
module tlp_prbs_lfsr
    import tlp_traffic_checker_pkg::*;
#(
    parameter int          TLP_WIDTH = 56,
    parameter logic [31:0] SEED      = LFSR_SEED_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_reseed,
    input  logic                 i_step,
    output logic [TLP_WIDTH-1:0] o_word
);
    logic [31:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = i_reseed ? SEED : i_step ? lfsr_step(lfsr_q) : lfsr_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    always_comb begin
        for (int i = 0; i < TLP_WIDTH; i++) o_word[i] = lfsr_q[i % 32];
    end

endmodule

// File: rtl/tlp_traffic_checker.sv
// tlp_traffic_checker: per-channel PRBS TLP generator and loopback checker (IDLE/RUN/DRAIN/DONE).
// Define TLP_CHECK_TIMEOUT_EN to build the per-channel receive watchdog.
module tlp_traffic_checker
    import tlp_traffic_checker_pkg::*;
#(
    parameter int          CHANNELS       = 2,
    parameter int          TLP_WIDTH      = 56,
    parameter int          CNT_WIDTH      = 16,
    parameter logic [31:0] LFSR_SEED      = LFSR_SEED_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [CHANNELS-1:0]           i_start,
    input  logic [CHANNELS-1:0]           i_stop,
    input  logic [CNT_WIDTH-1:0]          i_burst_len,
    input  logic [CHANNELS-1:0]           i_tlp_rdy,
    output logic [CHANNELS-1:0]           o_tlp_wr,
    output logic [CHANNELS*TLP_WIDTH-1:0] o_tlp_data,
    input  logic [CHANNELS-1:0]           i_tlp_valid,
    input  logic [CHANNELS*TLP_WIDTH-1:0] i_tlp_data,
    output logic [CHANNELS-1:0]           o_tlp_rd,
    output logic [CHANNELS*CNT_WIDTH-1:0] o_tx_cnt,
    output logic [CHANNELS*CNT_WIDTH-1:0] o_rx_cnt,
    output logic [CHANNELS*CNT_WIDTH-1:0] o_err_cnt,
    output logic [CHANNELS-1:0]           o_busy,
    output logic [CHANNELS-1:0]           o_done,
    output logic [CHANNELS-1:0]           o_pass,
    output logic [CHANNELS-1:0]           o_timeout
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_e               state_q, state_d;
        logic [CNT_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, err_q, err_d, burst_q;
        logic [TLP_WIDTH-1:0] tx_word, rx_word;
        logic                 wr, rd, busy, done, pass, launch, to_hit, to_q;

        assign launch = (state_q == ST_IDLE || state_q == ST_DONE) && i_start[c];

        always_ff @(posedge i_clk) begin
            if (i_rst) state_q <= ST_IDLE;
            else       state_q <= state_d;
        end

        // burst_len 0 never matches tx_d as an end condition: continuous mode runs until stop
        always_comb begin
            tx_d    = tx_q + CNT_WIDTH'(wr);
            rx_d    = rx_q + CNT_WIDTH'(rd);
            err_d   = err_q + CNT_WIDTH'(rd && i_tlp_data[c*TLP_WIDTH +: TLP_WIDTH] != rx_word && err_q != '1);
            state_d = launch ? ST_RUN :
                      to_hit ? ST_DONE :
                      (state_q == ST_RUN && (i_stop[c] || (burst_q != '0 && tx_d == burst_q))) ? ST_DRAIN :
                      (state_q == ST_DRAIN && rx_d == tx_q) ? ST_DONE : state_q;
        end

        always_comb begin
            busy = state_q == ST_RUN || state_q == ST_DRAIN;
            done = state_q == ST_DONE;
            pass = done && err_q == '0 && !to_q;
            wr   = !i_rst && state_q == ST_RUN && i_tlp_rdy[c] && (burst_q == '0 || tx_q != burst_q);
            rd   = !i_rst && busy && i_tlp_valid[c];
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                tx_q    <= '0;
                rx_q    <= '0;
                err_q   <= '0;
                burst_q <= '0;
            end else begin
                tx_q    <= launch ? '0 : tx_d;
                rx_q    <= launch ? '0 : rx_d;
                err_q   <= launch ? '0 : err_d;
                burst_q <= launch ? i_burst_len : burst_q;
            end
        end

`ifdef TLP_CHECK_TIMEOUT_EN
        localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
        logic [WW-1:0] wd_q;

        // counts cycles since the last read; fires on the TIMEOUT_CYCLES-th idle cycle
        assign to_hit = busy && !rd && wd_q == WW'(TIMEOUT_CYCLES - 1);

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                wd_q <= '0;
                to_q <= 1'b0;
            end else begin
                wd_q <= (launch || rd || !busy) ? '0 : wd_q + WW'(1);
                to_q <= launch ? 1'b0 : (to_q | to_hit);
            end
        end
`else
        assign to_hit = 1'b0;
        assign to_q   = 1'b0;
`endif

        tlp_prbs_lfsr #(.TLP_WIDTH(TLP_WIDTH), .SEED(LFSR_SEED)) u_tx_lfsr (
            .i_clk(i_clk), .i_rst(i_rst), .i_reseed(launch), .i_step(wr), .o_word(tx_word)
        );
        tlp_prbs_lfsr #(.TLP_WIDTH(TLP_WIDTH), .SEED(LFSR_SEED)) u_rx_lfsr (
            .i_clk(i_clk), .i_rst(i_rst), .i_reseed(launch), .i_step(rd), .o_word(rx_word)
        );

        assign o_tlp_wr[c]                            = wr;
        assign o_tlp_rd[c]                            = rd;
        assign o_tlp_data[c*TLP_WIDTH +: TLP_WIDTH]   = tx_word;
        assign o_tx_cnt[c*CNT_WIDTH +: CNT_WIDTH]     = tx_q;
        assign o_rx_cnt[c*CNT_WIDTH +: CNT_WIDTH]     = rx_q;
        assign o_err_cnt[c*CNT_WIDTH +: CNT_WIDTH]    = err_q;
        assign o_busy[c]                              = busy;
        assign o_done[c]                              = done;
        assign o_pass[c]                              = pass;
        assign o_timeout[c]                           = to_q;
    end

endmodule

// File: tb/tb_tlp_traffic_checker.sv
// tb_tlp_traffic_checker: directed loopback bench with a behavioural FWFT FIFO per channel.
module tb_tlp_traffic_checker;
    localparam int CH = 2;
    localparam int W  = 56;
    localparam int CW = 16;
    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam logic [W-1:0] SEED_W = 56'hE1_0001_ACE1_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic [CH-1:0]    start = '0, stop = '0, rdy, valid, rdy_fix = '0;
    logic [CW-1:0]    burst = '0;
    logic [CH*W-1:0]  rx_data;
    logic [CH-1:0]    o_tlp_wr, o_tlp_rd, o_busy, o_done, o_pass, o_timeout;
    logic [CH*W-1:0]  o_tlp_data;
    logic [CH*CW-1:0] o_tx_cnt, o_rx_cnt, o_err_cnt;

    int total = 0, bad = 0, viol = 0, n = 0, v0 = 0;
    bit rdy_rand = 0, rx_off = 0, flip_en = 0;
    logic [W-1:0] mem   [CH][512];
    logic [W-1:0] txlog [CH][1024];
    int wp [CH], rp [CH], rd_n [CH];

    tlp_traffic_checker #(
        .CHANNELS(CH), .TLP_WIDTH(W), .CNT_WIDTH(CW), .LFSR_SEED(SEED), .TIMEOUT_CYCLES(64)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_burst_len(burst),
        .i_tlp_rdy(rdy), .o_tlp_wr(o_tlp_wr), .o_tlp_data(o_tlp_data),
        .i_tlp_valid(valid), .i_tlp_data(rx_data), .o_tlp_rd(o_tlp_rd),
        .o_tx_cnt(o_tx_cnt), .o_rx_cnt(o_rx_cnt), .o_err_cnt(o_err_cnt),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout)
    );

    // loopback FIFO: transfers sampled at the edge, new head presented 1 time unit later
    initial begin
        rdy = '0; valid = '0; rx_data = '0;
    end
    always @(posedge clk) begin : fifo
        logic [CH-1:0] w, r, st;
        logic [CH*W-1:0] d;
        logic rs;
        w = o_tlp_wr; r = o_tlp_rd; d = o_tlp_data; st = start; rs = rst;
        if (rs && (w != '0 || r != '0)) viol++;
        for (int c = 0; c < CH; c++) begin
            if (w[c] && !rdy[c]) viol++;
            if (rs || st[c]) begin wp[c] = 0; rp[c] = 0; rd_n[c] = 0; end
            if (w[c]) begin
                mem[c][wp[c] % 512]    = d[c*W +: W];
                txlog[c][wp[c] % 1024] = d[c*W +: W];
                wp[c]++;
            end
            if (r[c]) begin rp[c]++; rd_n[c]++; end
        end
        #1;
        for (int c = 0; c < CH; c++) begin
            valid[c]         = !rx_off && wp[c] != rp[c];
            rx_data[c*W +: W] = mem[c][rp[c] % 512] ^ W'(flip_en && rd_n[c] == 4);
        end
        rdy = rdy_rand ? CH'($urandom_range(0, 3)) : rdy_fix;
    end

    function automatic logic [31:0] step(input logic [31:0] s);
        return s[31] ? ({s[30:0], 1'b0} ^ 32'h04C1_1DB7) : {s[30:0], 1'b0};
    endfunction

    function automatic int seq_errs(input int c, input int cnt);
        logic [31:0] s = SEED;
        int e = 0;
        for (int i = 0; i < cnt; i++) begin
            if (txlog[c][i] !== {s[23:0], s}) e++;
            s = step(s);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [CH-1:0] m);
        start = m;
        tick();
        start = '0;
    endtask

    task automatic wait_done(input logic [CH-1:0] m, input int lim, output int cyc);
        cyc = 0;
        do begin tick(); cyc++; end while ((o_done & m) != m && cyc < lim);
        total++;
        if ((o_done & m) != m) begin bad++; $display("FAIL wait_done: o_done=%b want %b within %0d cycles", o_done, m, lim); end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy_fix = 2'b11;
        tick(); tick();
        total++; if (o_tlp_wr !== 2'b00) begin bad++; $display("FAIL reset_wr: got %b want 00", o_tlp_wr); end
        total++; if ({o_busy, o_done, o_pass, o_timeout} !== 8'h0) begin bad++; $display("FAIL reset_status: got %h want 00", {o_busy, o_done, o_pass, o_timeout}); end
        total++; if ({o_tx_cnt, o_rx_cnt, o_err_cnt} !== '0) begin bad++; $display("FAIL reset_cnt: got %h want 0", {o_tx_cnt, o_rx_cnt, o_err_cnt}); end
        total++; if (o_tlp_data !== {SEED_W, SEED_W}) begin bad++; $display("FAIL reset_data: got %h want %h", o_tlp_data, {SEED_W, SEED_W}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_loopback();
        burst = 16;
        start = 2'b11;
        tick();
        start = '0;
        total++; if ({o_tlp_wr, o_busy} !== 4'hF) begin bad++; $display("FAIL loop_first_wr: wr=%b busy=%b want 11/11", o_tlp_wr, o_busy); end
        wait_done(2'b11, 100, n);
        total++; if (n !== 17) begin bad++; $display("FAIL loop_latency: got %0d want 17", n); end
        total++; if (o_tx_cnt !== {16'd16, 16'd16}) begin bad++; $display("FAIL loop_tx: got %h want 00100010", o_tx_cnt); end
        total++; if (o_rx_cnt !== {16'd16, 16'd16}) begin bad++; $display("FAIL loop_rx: got %h want 00100010", o_rx_cnt); end
        total++; if (o_err_cnt !== '0) begin bad++; $display("FAIL loop_err: got %h want 0", o_err_cnt); end
        total++; if ({o_pass, o_busy, o_timeout} !== 6'b11_00_00) begin bad++; $display("FAIL loop_status: pass=%b busy=%b to=%b want 11/00/00", o_pass, o_busy, o_timeout); end
        total++; if (seq_errs(0, 16) + seq_errs(1, 16) !== 0) begin bad++; $display("FAIL loop_seq: got %0d bad words want 0", seq_errs(0, 16) + seq_errs(1, 16)); end
    endtask

    task automatic test_backpressure();
        v0 = viol;
        rdy_rand = 1;
        pulse_start(2'b11);
        wait_done(2'b11, 400, n);
        rdy_rand = 0;
        tick();
        total++; if (o_tx_cnt !== {16'd16, 16'd16}) begin bad++; $display("FAIL bp_tx: got %h want 00100010", o_tx_cnt); end
        total++; if (viol !== v0) begin bad++; $display("FAIL bp_wr_without_rdy: got %0d want %0d", viol, v0); end
        total++; if (seq_errs(0, 16) + seq_errs(1, 16) !== 0) begin bad++; $display("FAIL bp_seq: got %0d bad words want 0", seq_errs(0, 16) + seq_errs(1, 16)); end
        total++; if (o_pass !== 2'b11) begin bad++; $display("FAIL bp_pass: got %b want 11", o_pass); end
    endtask

    task automatic test_bit_error();
        flip_en = 1;
        pulse_start(2'b11);
        wait_done(2'b11, 100, n);
        flip_en = 0;
        total++; if (o_err_cnt !== {16'd1, 16'd1}) begin bad++; $display("FAIL berr_cnt: got %h want 00010001", o_err_cnt); end
        total++; if (o_rx_cnt !== {16'd16, 16'd16}) begin bad++; $display("FAIL berr_rx: got %h want 00100010", o_rx_cnt); end
        total++; if (o_pass !== 2'b00) begin bad++; $display("FAIL berr_pass: got %b want 00", o_pass); end
    endtask

    task automatic test_continuous();
        burst = 0;
        pulse_start(2'b11);
        n = 0;
        while (o_tx_cnt[CW-1:0] != 16'd299 && n < 1000) begin tick(); n++; end
        total++; if (o_tx_cnt[CW-1:0] !== 16'd299) begin bad++; $display("FAIL cont_reach: got %0d want 299", o_tx_cnt[CW-1:0]); end
        stop = 2'b11;
        tick();
        stop = '0;
        total++; if ({o_busy, o_done} !== 4'b1100) begin bad++; $display("FAIL cont_drain: busy=%b done=%b want 11/00", o_busy, o_done); end
        wait_done(2'b11, 50, n);
        total++; if ({o_tx_cnt, o_rx_cnt} !== {16'd300, 16'd300, 16'd300, 16'd300}) begin bad++; $display("FAIL cont_cnt: tx=%h rx=%h want 012c012c", o_tx_cnt, o_rx_cnt); end
        total++; if (seq_errs(0, 300) !== 0) begin bad++; $display("FAIL cont_seq: got %0d bad words want 0", seq_errs(0, 300)); end
        total++; if (o_pass !== 2'b11) begin bad++; $display("FAIL cont_pass: got %b want 11", o_pass); end
    endtask

    task automatic test_start_stop();
        burst = 0;
        start = 2'b11; stop = 2'b11;
        tick();
        start = '0; stop = '0;
        total++; if (o_busy !== 2'b11) begin bad++; $display("FAIL ss_start_wins: busy=%b want 11", o_busy); end
        tick(); tick(); tick();
        stop = 2'b11;
        tick();
        stop = '0;
        wait_done(2'b11, 20, n);
        total++; if ({o_tx_cnt, o_rx_cnt} !== {16'd4, 16'd4, 16'd4, 16'd4}) begin bad++; $display("FAIL ss_cnt: tx=%h rx=%h want 00040004", o_tx_cnt, o_rx_cnt); end
    endtask

    task automatic test_reset_mid();
        burst = 16;
        pulse_start(2'b11);
        tick(); tick(); tick(); tick();
        v0 = viol;
        rst = 1'b1;
        #1;
        total++; if ({o_tlp_wr, o_tlp_rd} !== 4'h0) begin bad++; $display("FAIL rmid_gate: wr=%b rd=%b want 00/00", o_tlp_wr, o_tlp_rd); end
        tick();
        total++; if ({o_busy, o_done, o_pass} !== 6'h0) begin bad++; $display("FAIL rmid_status: got %b want 0", {o_busy, o_done, o_pass}); end
        total++; if ({o_tx_cnt, o_rx_cnt} !== '0) begin bad++; $display("FAIL rmid_cnt: tx=%h rx=%h want 0", o_tx_cnt, o_rx_cnt); end
        total++; if (o_tlp_data !== {SEED_W, SEED_W}) begin bad++; $display("FAIL rmid_data: got %h want %h", o_tlp_data, {SEED_W, SEED_W}); end
        tick();
        rst = 1'b0;
        total++; if (viol !== v0) begin bad++; $display("FAIL rmid_strobe: got %0d want %0d", viol, v0); end
        pulse_start(2'b11);
        total++; if (o_tlp_data[W-1:0] !== SEED_W) begin bad++; $display("FAIL rmid_restart_word: got %h want %h", o_tlp_data[W-1:0], SEED_W); end
        wait_done(2'b11, 100, n);
        total++; if (o_pass !== 2'b11) begin bad++; $display("FAIL rmid_pass: got %b want 11", o_pass); end
    endtask

`ifdef TLP_CHECK_TIMEOUT_EN
    task automatic test_timeout();
        rx_off = 1;
        pulse_start(2'b11);
        wait_done(2'b11, 200, n);
        rx_off = 0;
        total++; if (n !== 64) begin bad++; $display("FAIL to_latency: got %0d want 64", n); end
        total++; if ({o_timeout, o_pass} !== 4'b1100) begin bad++; $display("FAIL to_status: to=%b pass=%b want 11/00", o_timeout, o_pass); end
        total++; if (o_rx_cnt !== '0) begin bad++; $display("FAIL to_rx: got %h want 0", o_rx_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_loopback();
        total++; if (o_timeout !== 2'b00) begin bad++; $display("FAIL no_timeout: got %b want 00", o_timeout); end
        test_backpressure();
        test_bit_error();
        test_continuous();
        test_start_stop();
        test_reset_mid();
`ifdef TLP_CHECK_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
